tactile_pwm_driver: RTL and testbench

TACTILE_PWM_DRIVER -- requirements
Module: tactile_pwm_driver

---
 rtl/tactile_pkg.sv | 27 ++
 rtl/pwm_timebase.sv | 48 ++++
 rtl/tactile_pwm_driver.sv | 105 ++++++++++
 tb/tb_tactile_pwm_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/tactile_pkg.sv
// Shared constants and types for the tactile PWM driver.
// The optional soft-start ramp helper is built only when TACTILE_RAMP_EN is defined.
package tactile_pkg;

    localparam int unsigned NUM_MOTORS = 4;
    localparam int unsigned DUTY_W     = 4;
    localparam int unsigned PWM_STEPS  = 15;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned CMD_W      = NUM_MOTORS * DUTY_W;

    typedef logic [DUTY_W-1:0] duty_t;

`ifdef TACTILE_RAMP_EN
    // Move one duty step toward the target, holding once it is reached.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = cur + 1'b1;
        end else if (cur > tgt) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction
`endif

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clk prescaler producing a tick every CLK_DIV clks, and a
// 0..PWM_STEPS-1 period counter advanced by that tick. wrap marks the tick
// that ends a period.
module pwm_timebase
    import tactile_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [15:0]      PRE_LAST = 16'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_STEPS - 1);

    logic [15:0]      presc_q, presc_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Tick/wrap decode and next-state for prescaler and period counter.
    always_comb begin
        tick    = (presc_q == PRE_LAST);
        wrap    = tick && (count_q == CNT_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (tick) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            count_q <= '0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tactile_pwm_driver.sv
// Four-channel tactile motor PWM driver. cmd_in carries one 4-bit intensity
// per motor; new intensities take effect only at PWM period boundaries so a
// period is never cut short. Define TACTILE_RAMP_EN to make each applied duty
// walk one step per period toward its target (soft start/stop).
module tactile_pwm_driver
    import tactile_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cmd_in,
    output logic [3:0]  motor_pwm,
    output logic        period_start,
    output logic        update_ack,
    output logic        pending
);

    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic [CMD_W-1:0]      cmd_q;
    logic [CMD_W-1:0]      target_q, target_d;
    logic [CMD_W-1:0]      duty_q, duty_d;
    logic [NUM_MOTORS-1:0] pwm_q, pwm_d;
    logic                  start_q;
    logic                  ack_q, ack_d;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .count   (count),
        .wrap    (wrap)
    );

    // Targets load from the registered command only on the wrapping tick.
    always_comb begin
        target_d = target_q;
        ack_d    = 1'b0;
        if (wrap) begin
            target_d = cmd_q;
            ack_d    = (cmd_q != target_q);
        end
    end

    // Applied duty: either follows the target directly or ramps toward it.
    always_comb begin
`ifdef TACTILE_RAMP_EN
        duty_d = duty_q;
        if (wrap) begin
            for (int unsigned k = 0; k < NUM_MOTORS; k++) begin
                duty_d[k*DUTY_W +: DUTY_W] = step_toward(duty_q[k*DUTY_W +: DUTY_W],
                                                         target_d[k*DUTY_W +: DUTY_W]);
            end
        end
`else
        duty_d = target_d;
`endif
    end

    // PWM compare uses next-cycle count and duty so the registered outputs
    // line up with the period count they belong to.
    always_comb begin
        count_next = count;
        if (wrap) begin
            count_next = '0;
        end else if (tick) begin
            count_next = count + 1'b1;
        end
        pwm_d = '0;
        for (int unsigned k = 0; k < NUM_MOTORS; k++) begin
            pwm_d[k] = (count_next < duty_d[k*DUTY_W +: DUTY_W]);
        end
    end

    // Command capture, applied state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q    <= '0;
            target_q <= '0;
            duty_q   <= '0;
            pwm_q    <= '0;
            start_q  <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cmd_q    <= cmd_in;
            target_q <= target_d;
            duty_q   <= duty_d;
            pwm_q    <= pwm_d;
            start_q  <= wrap;
            ack_q    <= ack_d;
        end
    end

    assign motor_pwm    = pwm_q;
    assign period_start = start_q;
    assign update_ack   = ack_q;
    assign pending      = (cmd_q != target_q);

endmodule

// File: tb/tb_tactile_pwm_driver.sv
// Scoreboard bench for tactile_pwm_driver with CLK_DIV=4 (60-clk periods).
// Stimulus pushes the expected ack cycle and duty word for each command that
// should take effect; the monitor pops on every update_ack and measures the
// following period's PWM high time per motor.
module tb_tactile_pwm_driver;

    localparam int unsigned D = 4;
    localparam int unsigned P = 15 * D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cmd_in = 16'h0000;
    logic [3:0]  motor_pwm;
    logic        period_start;
    logic        update_ack;
    logic        pending;

    tactile_pwm_driver #(
        .CLK_DIV (D)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cmd_in       (cmd_in),
        .motor_pwm    (motor_pwm),
        .period_start (period_start),
        .update_ack   (update_ack),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycle;
        logic [15:0] duty;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_start = -1;

    // Cycle n is the interval following the n-th rising edge after release.
    always @(posedge clk) begin
        if (reset_n) cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (reset_n && period_start && first_start < 0) first_start = cyc;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: each update_ack pops one expectation and measures one period.
    initial begin : monitor
        exp_t e;
        int   hi [4];
        forever begin
            @(negedge clk);
            if (reset_n && update_ack) begin
                if (sb.size() == 0) begin
                    check("unexpected update_ack", int'(update_ack), 0);
                end else begin
                    e = sb.pop_front();
                    check("update_ack cycle", cyc, e.cycle);
                    for (int k = 0; k < 4; k++) hi[k] = 0;
                    for (int i = 0; i < int'(P); i++) begin
                        if (i > 0) begin
                            @(negedge clk);
                            if (reset_n && update_ack)
                                check("update_ack inside period", int'(update_ack), 0);
                        end
                        for (int k = 0; k < 4; k++) hi[k] += int'(motor_pwm[k]);
                    end
                    for (int k = 0; k < 4; k++)
                        check($sformatf("motor%0d high clks", k), hi[k],
                              int'(e.duty[4*k +: 4]) * int'(D));
                end
            end
        end
    end

    initial begin : stimulus
        int hi0;
        cmd_in  = 16'hFFFF;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset motor_pwm", int'(motor_pwm), 0);
        check("reset period_start", int'(period_start), 0);
        check("reset update_ack", int'(update_ack), 0);
        check("reset pending", int'(pending), 0);
        cmd_in = 16'h0000;
        #1 reset_n = 1'b1;

`ifdef TACTILE_RAMP_EN
        at_cycle(10);
        cmd_in = 16'h000F;
        sb.push_back('{cycle: 60, duty: 16'h0001});
        for (int p = 1; p <= 10; p++) begin
            hi0 = 0;
            for (int i = 0; i < int'(P); i++) begin
                at_cycle(p * int'(P) + i);
                hi0 += int'(motor_pwm[0]);
            end
            check($sformatf("ramp period %0d motor0 high clks", p), hi0, p * int'(D));
        end
        at_cycle(11 * int'(P) + 5);
        check("mid-ramp motor0 before reset", int'(motor_pwm[0]), 1);
        reset_n = 1'b0;
        #1;
        check("motor_pwm right after reset", int'(motor_pwm), 0);
`else
        at_cycle(30);
        check("motor_pwm idle first period", int'(motor_pwm), 0);

        // Mid-period command: pending until the boundary at cycle 120.
        at_cycle(70);
        cmd_in = 16'h0F80;
        sb.push_back('{cycle: 120, duty: 16'h0F80});
        at_cycle(75);
        check("pending after mid-period cmd", int'(pending), 1);
        check("motor_pwm unchanged mid-period", int'(motor_pwm), 0);
        at_cycle(119);
        check("pending on boundary clk", int'(pending), 1);
        at_cycle(120);
        check("pending cleared with ack", int'(pending), 0);
        check("first period_start cycle", first_start, 60);

        // Three changes in one period collapse into one update.
        at_cycle(130);
        cmd_in = 16'h1111;
        at_cycle(140);
        cmd_in = 16'h2222;
        at_cycle(150);
        cmd_in = 16'h3333;
        sb.push_back('{cycle: 180, duty: 16'h3333});

        // cmd_q holds 4444 on the boundary clk (239): loaded at 240.
        at_cycle(238);
        cmd_in = 16'h4444;
        sb.push_back('{cycle: 240, duty: 16'h4444});
        // cmd_q takes 5555 one clk after the boundary clk: waits until 360.
        at_cycle(299);
        cmd_in = 16'h5555;
        sb.push_back('{cycle: 360, duty: 16'h5555});
        at_cycle(300);
        check("pending after late change", int'(pending), 1);

        // Reset mid-period forces motors low at once.
        at_cycle(425);
        check("motor_pwm before reset", int'(motor_pwm), 15);
        reset_n = 1'b0;
        #1;
        check("motor_pwm right after reset", int'(motor_pwm), 0);
        check("pending right after reset", int'(pending), 0);
        check("update_ack right after reset", int'(update_ack), 0);
`endif
        repeat (2) @(negedge clk);
        check("outstanding expected acks", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
